// File: rtl/usb3_hp_rx_check.sv
// USB 3.0 header-packet RX checker: gathers 3 header DWORDs + CRC/LCW word, verifies CRC-16 and CRC-5.
// Latency: results register on the edge accepting word 3; no backpressure, in_valid may gap up to MAX_GAP-1 cycles.
// Optional saturating CRC error counter enabled by USB3_HP_RX_ERR_CNT_EN.
module usb3_hp_rx_check #(
  parameter int unsigned MAX_GAP = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hp_start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic [95:0] hdr_out,
  output logic [10:0] lcw_out,
  output logic [2:0]  hdr_seq,
  output logic        out_valid,
  output logic        crc16_ok,
  output logic        crc5_ok,
  output logic        abort,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3} state_t;

  localparam logic [3:0] GAP_LIM = 4'(MAX_GAP - 1);

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [3:0]  r_gap;
  logic [31:0] r_w0, r_w1, r_w2;
  logic [95:0] r_hdr_out;
  logic [10:0] r_lcw_out;
  logic        r_out_valid, r_crc16_ok, r_crc5_ok, r_abort;

  logic [15:0] w_crc16_exp;
  logic [4:0]  w_crc5_exp;
  logic        w_crc16_ok, w_crc5_ok, w_w3_accept;

  // Galois LFSR, data bit 0 shifted in first
  function automatic logic [15:0] f_crc16_word(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 32; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [4:0] f_crc5(input logic [10:0] d);
    logic [4:0] r;
    logic       fb;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ d[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return r;
  endfunction

  function automatic logic [15:0] f_rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  assign w_crc16_exp = ~f_rev16(r_lfsr);
  assign w_crc5_exp  = ~f_crc5(in_data[26:16]);
  assign w_crc16_ok  = (w_crc16_exp == in_data[15:0]);
  assign w_crc5_ok   = (w_crc5_exp == in_data[31:27]);
  assign w_w3_accept = (r_state == S_W3) && in_valid && !hp_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 16'hFFFF;
      r_gap       <= 4'd0;
      r_w0        <= 32'd0;
      r_w1        <= 32'd0;
      r_w2        <= 32'd0;
      r_hdr_out   <= 96'd0;
      r_lcw_out   <= 11'd0;
      r_out_valid <= 1'b0;
      r_crc16_ok  <= 1'b0;
      r_crc5_ok   <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_abort     <= 1'b0;
      // The start strobe owns its cycle; any same-cycle word is dropped
      if (hp_start) begin
        r_abort <= (r_state != S_IDLE);
        r_state <= S_W0;
        r_lfsr  <= 16'hFFFF;
        r_gap   <= 4'd0;
      end else if (r_state != S_IDLE) begin
        if (in_valid) begin
          r_gap <= 4'd0;
          case (r_state)
            S_W0: begin r_w0 <= in_data; r_lfsr <= f_crc16_word(r_lfsr, in_data); r_state <= S_W1; end
            S_W1: begin r_w1 <= in_data; r_lfsr <= f_crc16_word(r_lfsr, in_data); r_state <= S_W2; end
            S_W2: begin r_w2 <= in_data; r_lfsr <= f_crc16_word(r_lfsr, in_data); r_state <= S_W3; end
            S_W3: begin
              r_hdr_out   <= {r_w2, r_w1, r_w0};
              r_lcw_out   <= in_data[26:16];
              r_crc16_ok  <= w_crc16_ok;
              r_crc5_ok   <= w_crc5_ok;
              r_out_valid <= 1'b1;
              r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end else if (r_gap == GAP_LIM) begin
          r_abort <= 1'b1;
          r_gap   <= 4'd0;
          r_state <= S_IDLE;
        end else begin
          r_gap <= r_gap + 4'd1;
        end
      end
    end
  end

`ifdef USB3_HP_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'h00;
    end else if (w_w3_accept && !(w_crc16_ok && w_crc5_ok) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = w_w3_accept;
  assign err_cnt  = 8'h00;
`endif

  assign hdr_out   = r_hdr_out;
  assign lcw_out   = r_lcw_out;
  assign hdr_seq   = r_lcw_out[2:0];
  assign out_valid = r_out_valid;
  assign crc16_ok  = r_crc16_ok;
  assign crc5_ok   = r_crc5_ok;
  assign abort     = r_abort;

endmodule

// File: tb/tb_usb3_hp_rx_check.sv
// Directed bench for usb3_hp_rx_check; expected packet results are queued at stimulus time
// and compared when out_valid/abort pulses, using an independent reflected-form CRC generator.
module tb_usb3_hp_rx_check;

`ifdef USB3_HP_RX_ERR_CNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hp_start, in_valid;
  logic [31:0] in_data;
  logic [95:0] hdr_out;
  logic [10:0] lcw_out;
  logic [2:0]  hdr_seq;
  logic        out_valid, crc16_ok, crc5_ok, abort;
  logic [7:0]  err_cnt;

  usb3_hp_rx_check #(.MAX_GAP(15)) dut (
    .clk(clk), .rst(rst), .hp_start(hp_start), .in_valid(in_valid), .in_data(in_data),
    .hdr_out(hdr_out), .lcw_out(lcw_out), .hdr_seq(hdr_seq), .out_valid(out_valid),
    .crc16_ok(crc16_ok), .crc5_ok(crc5_ok), .abort(abort), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_abort;
    logic [95:0] hdr;
    logic [10:0] lcw;
    logic        c16;
    logic        c5;
    logic [7:0]  err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] exp_err = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmit-side generator model, reflected register form
  function automatic logic [15:0] tx_crc16(input logic [95:0] hdr);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 96; i++) begin
      fb = c[0] ^ hdr[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hD008;
    end
    return ~c;
  endfunction

  function automatic logic [4:0] tx_crc5(input logic [10:0] lcw);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ lcw[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    return ~c;
  endfunction

  function automatic logic [31:0] mk_w3(input logic [10:0] lcw, input logic [31:0] w0, w1, w2);
    return {tx_crc5(lcw), lcw, tx_crc16({w2, w1, w0})};
  endfunction

  task automatic drive(input logic hs, input logic v, input logic [31:0] d);
    hp_start = hs;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic push_abort();
    exp_t e;
    e = '{is_abort: 1'b1, hdr: 96'd0, lcw: 11'd0, c16: 1'b0, c5: 1'b0, err: 8'd0, due: -1};
    sb.push_back(e);
  endtask

  // gap_at = word index preceded by gapn idle cycles (-1: none); sv = in_valid alongside hp_start
  task automatic pkt(input logic [31:0] w0, w1, w2, w3, input int gap_at, input int gapn, input logic sv);
    logic [31:0] w[4];
    exp_t e;
    w = '{w0, w1, w2, w3};
    drive(1'b1, sv, sv ? 32'hDEADBEEF : 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == gap_at) begin
        if (gapn >= 15) begin
          push_abort();
          repeat (gapn) drive(1'b0, 1'b0, 32'h0);
          return;
        end
        repeat (gapn) drive(1'b0, 1'b0, 32'h0);
      end
      if (k == 3) begin
        e.is_abort = 1'b0;
        e.hdr = {w2, w1, w0};
        e.lcw = w3[26:16];
        e.c16 = (w3[15:0] == tx_crc16({w2, w1, w0}));
        e.c5  = (w3[31:27] == tx_crc5(w3[26:16]));
        if (FEAT && !(e.c16 && e.c5) && exp_err != 8'hFF) exp_err = exp_err + 8'h01;
        e.err = exp_err;
        e.due = cyc + 1;
        sb.push_back(e);
      end
      drive(1'b0, 1'b1, w[k]);
    end
    drive(1'b0, 1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("pulse_exclusive", {126'd0, out_valid, abort} == 128'd3, 128'd0);
      if (out_valid || abort) begin
        chk("event_expected", sb.size() != 0, 128'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("event_kind", abort, e.is_abort);
          if (!e.is_abort) begin
            chk("latency", cyc, e.due);
            chk("hdr_out", hdr_out, e.hdr);
            chk("lcw_out", lcw_out, e.lcw);
            chk("hdr_seq", hdr_seq, e.lcw[2:0]);
            chk("crc16_ok", crc16_ok, e.c16);
            chk("crc5_ok", crc5_ok, e.c5);
            chk("err_cnt", err_cnt, e.err);
          end
        end
      end
    end
  end

  localparam logic [31:0] A = 32'h11223344, B = 32'h55667788, C = 32'h99AABBCC;

  initial begin
    logic [31:0] w3g, w3b;
    w3g = mk_w3(11'h005, A, B, C);
    rst = 1'b1; hp_start = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_hdr_out", hdr_out, 96'd0);
    chk("rst_lcw_out", lcw_out, 11'd0);
    chk("rst_flags", {out_valid, crc16_ok, crc5_ok, abort}, 4'd0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hCAFEF00D);

    pkt(A, B, C, w3g, -1, 0, 1'b0);
    chk("good_seq_direct", hdr_seq, 3'h5);
    chk("good_hdr_direct", hdr_out, 96'h99AABBCC_55667788_11223344);
    pkt(A, B ^ 32'h1, C, w3g, -1, 0, 1'b0);
    pkt(A, B, C, w3g ^ (32'h1 << 27), -1, 0, 1'b0);
    chk("err_after_corrupt", err_cnt, FEAT ? 8'd2 : 8'd0);

    pkt(A, B, C, w3g, 2, 14, 1'b0);
    pkt(A, B, C, w3g, 2, 15, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 32'h0);
    w3b = mk_w3(11'h3A6, 32'h0BADF00D, 32'h12345678, 32'hFEDCBA98);
    pkt(32'h0BADF00D, 32'h12345678, 32'hFEDCBA98, w3b, -1, 0, 1'b1);

    drive(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'hAAAA5555);
    drive(1'b0, 1'b1, 32'h5555AAAA);
    push_abort();
    pkt(32'h0BADF00D, 32'h12345678, 32'hFEDCBA98, w3b, -1, 0, 1'b0);

    drive(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, A);
    drive(1'b0, 1'b1, B);
    rst = 1'b1;
    #1;
    chk("midrst_hdr_out", hdr_out, 96'd0);
    chk("midrst_lcw_seq", {lcw_out, hdr_seq}, 14'd0);
    chk("midrst_flags", {out_valid, crc16_ok, crc5_ok, abort}, 4'd0);
    chk("midrst_err_cnt", err_cnt, 8'd0);
    exp_err = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    pkt(A, B, C, w3g, -1, 0, 1'b0);

    for (int n = 0; n < 260; n++) pkt(A, B, C ^ 32'h8000_0000, w3g, -1, 0, 1'b0);
    chk("err_saturated", err_cnt, FEAT ? 8'hFF : 8'h00);

    repeat (20) drive(1'b0, 1'b0, 32'h0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb3_hp_rx_check.md
Name: usb3_hp_rx_check

Overview:
- Receive-side checker for USB 3.0 link-layer header packets.
- Sits after the descrambler/ordered-set detector and before the link-layer RX state machine.
- Collects the 4 DWORDs that follow an HPSTART (3 header DWORDs, then CRC-16 plus link control word), recomputes CRC-16 and CRC-5, and presents the header with pass/fail flags.
- Its CRC algorithms match the team's transmit-side CRC generators bit-for-bit.

Parameters:
- MAX_GAP, 15, max idle cycles allowed between accepted words mid-packet before abort (4-bit gap counter; legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- hp_start  in  1  one-cycle strobe: HPSTART ordered set detected; next accepted word is word 0
- in_valid  in  1  in_data holds a packet word
- in_data  in  32  packet word
- hdr_out  out  96  {word2, word1, word0} of the last completed packet
- lcw_out  out  11  link control word bits [10:0]
- hdr_seq  out  3  lcw_out[2:0], header sequence number
- out_valid  out  1  one-cycle pulse: packet complete, outputs valid
- crc16_ok  out  1  CRC-16 matched (qualified by out_valid, held until next out_valid)
- crc5_ok  out  1  CRC-5 matched (same qualification)
- abort  out  1  one-cycle pulse: packet abandoned (gap timeout or restart)
- err_cnt  out  8  saturating CRC error counter (optional feature only)

Behaviour:
- Reset values: hdr_out=0, lcw_out=0, out_valid=0, crc16_ok=0, crc5_ok=0, abort=0, err_cnt=0. FSM=IDLE, LFSR=16'hFFFF.
- FSM states: IDLE, W0, W1, W2, W3.
  - IDLE: in_valid ignored. hp_start -> W0, LFSR seeded 16'hFFFF, gap counter cleared.
  - W0..W2: on in_valid, word stored into hdr_out slot 0..2; LFSR advanced over 32 bits (LSB first); next state.
  - W3: on in_valid, check and register results; -> IDLE.
- CRC-16 algorithm:
  - Polynomial x^16+x^12+x^3+x+1 (0x100B), seed 0xFFFF.
  - Each word processed bit 0 first.
  - Expected value = bitwise inverse of the bit-reversed remainder.
  - Compared against in_data[15:0] of word 3.
- CRC-5 algorithm:
  - Polynomial x^5+x^2+1, seed 5'h1F.
  - Computed over in_data[26:16] of word 3, bit 16 first.
  - Expected value = inverse of remainder; compared against in_data[31:27].
- Latency: out_valid, crc16_ok, crc5_ok, hdr_out, lcw_out all update on the clock edge that accepts word 3. They are visible the cycle after word 3 is presented.
- Outputs hold until the next out_valid; they are not cleared by abort.
- in_valid may deassert between words. The gap counter increments each non-accepting cycle in W0..W3 and clears on each accepted word.
  - Gap counter reaching MAX_GAP: abort pulse, -> IDLE, no out_valid.
- hp_start in any W state (restart): abort pulse, reseed LFSR, -> W0.
  - Same-cycle in_valid is ignored, since the start strobe owns that cycle.
- hp_start in IDLE together with in_valid: start only; the word is not consumed.
- rst mid-packet: immediate return to reset values; no out_valid or abort pulse.
- out_valid and abort are never asserted in the same cycle.

Optional Feature:
- Macro USB3_HP_RX_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on each out_valid where crc16_ok=0 or crc5_ok=0; one increment per packet even if both fail.
  - Saturates at 8'hFF; cleared only by rst.
- Undefined: err_cnt tied to 8'h00; no counter logic is synthesized.

Test Plan:
- Good packet: hp_start, then back-to-back words 0x11223344, 0x55667788, 0x99AABBCC, and {LCW 11'h005 with correct CRC-5, correct CRC-16} from the transmit-side generator model -> out_valid 1 cycle after word 3, crc16_ok=1, crc5_ok=1, hdr_out=0x99AABBCC_55667788_11223344, hdr_seq=3'h5.
- Corruption: same packet with word1 bit 0 flipped -> crc16_ok=0, crc5_ok=1; separately CRC-5 field XOR 5'h01 -> crc16_ok=1, crc5_ok=0. With USB3_HP_RX_ERR_CNT_EN, err_cnt=2 after both.
- Gaps: good packet with 14 idle cycles between words 1 and 2 -> accepted, ok flags=1. Same with 15 idle cycles -> abort pulse, no out_valid.
- Restart: hp_start after word 1, then a full good packet -> exactly one abort, then one out_valid with flags=1 and hdr_out from the second packet.
- Reset mid-packet: rst asserted during W2 -> all outputs 0 immediately; next good packet -> normal out_valid, crc16_ok=1.
- Saturation (feature on): 260 bad packets -> err_cnt=8'hFF. Feature off -> err_cnt=0 throughout.
